// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline register with skid buffer: fully registered valid/ready
// handshake on both sides, in-order delivery, synchronous flush.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  state_t state, state_nxt;
  entry_t main_q, skid_q, in_entry;
  logic   accept, drain;

  assign in_entry = {in_data, in_rd, in_ctrl};

  // Handshakes use the state register directly; reset already holds every
  // flop, so the rst gating of in_ready is only needed on the port.
  assign accept = in_valid  && (state != TWO);
  assign drain  = out_ready && (state != EMPTY);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves a value unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (accept) state_nxt = ONE;
        ONE: begin
          if (accept && !drain)      state_nxt = TWO;
          else if (!accept && drain) state_nxt = EMPTY;
        end
        TWO:     if (drain) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_ctrl  = '0;
    occupancy = state;
    case (state)
      EMPTY: in_ready = rst;
      ONE: begin
        in_ready  = rst;
        out_valid = 1'b1;
        out_ctrl  = main_q.ctrl;
      end
      TWO: begin
        out_valid = 1'b1;
        out_ctrl  = main_q.ctrl;
      end
      default: ;
    endcase
  end

  // NOTE: the payload registers are reset too, because out_data/out_rd and
  // the skid contents must read zero while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      case (state)
        EMPTY: if (accept) main_q <= in_entry;
        ONE: begin
          if (accept && drain) main_q <= in_entry;
          else if (accept)     skid_q <= in_entry;
        end
        TWO:   if (drain) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  // Payload holds its last value when the stage empties; only ctrl is masked.
  assign out_data = main_q.data;
  assign out_rd   = main_q.rd;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, async reset
// sequence, then random traffic against a queue-based reference model.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_rd;
  logic [5:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [5:0]  out_ctrl;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  pipe_stage_skid #(.DATA_W(32), .RD_W(5), .CTRL_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_rd     (in_rd),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] din;
    logic        ov;
    logic [31:0] dout;
    logic [1:0]  occ;
    logic        irdy;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  r;
    logic [5:0]  c;
  } ent_t;

  vec_t vecs[16];
  ent_t q[$];
  ent_t last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                              input logic [31:0] din, input logic ov,
                              input logic [31:0] dout, input logic [1:0] occ,
                              input logic irdy);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.din = din;
    v.ov = ov; v.dout = dout; v.occ = occ; v.irdy = irdy;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_rd = '0; in_ctrl = '0;
    #23;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    // pass-through
    vecs[0]  = mk(1, 1, 0, 32'h11, 1, 32'h11, 2'd1, 1);
    vecs[1]  = mk(1, 1, 0, 32'h22, 1, 32'h22, 2'd1, 1);
    vecs[2]  = mk(1, 1, 0, 32'h33, 1, 32'h33, 2'd1, 1);
    vecs[3]  = mk(0, 1, 0, 32'h00, 0, 32'h33, 2'd0, 1);
    // back-pressure fills main then skid; 0xC is held upstream
    vecs[4]  = mk(1, 0, 0, 32'h0A, 1, 32'h0A, 2'd1, 1);
    vecs[5]  = mk(1, 0, 0, 32'h0B, 1, 32'h0A, 2'd2, 0);
    vecs[6]  = mk(1, 0, 0, 32'h0C, 1, 32'h0A, 2'd2, 0);
    vecs[7]  = mk(1, 1, 0, 32'h0C, 1, 32'h0B, 2'd1, 1);
    vecs[8]  = mk(1, 1, 0, 32'h0C, 1, 32'h0C, 2'd1, 1);
    vecs[9]  = mk(0, 1, 0, 32'h00, 0, 32'h0C, 2'd0, 1);
    // simultaneous in/out while ONE
    vecs[10] = mk(1, 0, 0, 32'h05, 1, 32'h05, 2'd1, 1);
    vecs[11] = mk(1, 1, 0, 32'h06, 1, 32'h06, 2'd1, 1);
    // flush while TWO discards the presented 0x9
    vecs[12] = mk(1, 0, 0, 32'h07, 1, 32'h06, 2'd2, 0);
    vecs[13] = mk(1, 0, 1, 32'h09, 0, 32'h06, 2'd0, 1);
    vecs[14] = mk(0, 1, 0, 32'h00, 0, 32'h06, 2'd0, 1);
    vecs[15] = mk(0, 1, 0, 32'h00, 0, 32'h06, 2'd0, 1);

    rst = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_rd = '0; in_ctrl = '0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_rd",    out_rd,    0);
    check("rst_out_ctrl",  out_ctrl,  0);
    check("rst_occupancy", occupancy, 0);
    #21;
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 16; i++) begin
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      in_data   = vecs[i].din;
      in_rd     = vecs[i].din[4:0];
      in_ctrl   = 6'h01;
      step();
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ov);
      check($sformatf("vec%0d_out_data", i),  out_data,  vecs[i].dout);
      check($sformatf("vec%0d_out_rd", i),    out_rd,    vecs[i].dout[4:0]);
      check($sformatf("vec%0d_out_ctrl", i),  out_ctrl,  vecs[i].ov ? 6'h01 : 6'h00);
      check($sformatf("vec%0d_occupancy", i), occupancy, vecs[i].occ);
      check($sformatf("vec%0d_in_ready", i),  in_ready,  vecs[i].irdy);
    end
    flush = 1'b0;

    // async reset mid-cycle with two entries held
    in_valid = 1'b1; out_ready = 1'b0; in_ctrl = 6'h3F;
    in_data = 32'h21; in_rd = 5'h01; step();
    in_data = 32'h22; in_rd = 5'h02; step();
    check("pre_arst_occupancy", occupancy, 2);
    in_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready",  in_ready,  0);
    check("arst_out_data",  out_data,  0);
    check("arst_out_rd",    out_rd,    0);
    check("arst_out_ctrl",  out_ctrl,  0);
    check("arst_occupancy", occupancy, 0);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_release_in_ready", in_ready, 1);
    in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h77; in_rd = 5'h17; in_ctrl = 6'h05;
    step();
    check("after_arst_out_valid", out_valid, 1);
    check("after_arst_out_data",  out_data,  32'h77);
    check("after_arst_out_ctrl",  out_ctrl,  6'h05);
    check("after_arst_occupancy", occupancy, 1);
    in_valid = 1'b0;
    step();
    check("after_arst_drain_valid", out_valid, 0);

    // random traffic against a FIFO model of depth 2
    do_reset();
    q.delete();
    last = '{d: 32'h0, r: 5'h0, c: 6'h0};
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic in_fire, out_fire;
      ent_t e;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_data   = $urandom;
      in_rd     = 5'($urandom);
      in_ctrl   = 6'($urandom);
      e = '{d: in_data, r: in_rd, c: in_ctrl};
      in_fire  = in_valid && (q.size() < 2);
      out_fire = out_ready && (q.size() > 0);
      step();
      if (flush) begin
        q.delete();
      end else begin
        if (out_fire) void'(q.pop_front());
        if (in_fire)  q.push_back(e);
      end
      if (q.size() > 0) last = q[0];
      check("rnd_occupancy", occupancy, q.size());
      check("rnd_out_valid", out_valid, q.size() > 0);
      check("rnd_in_ready",  in_ready,  q.size() < 2);
      check("rnd_out_data",  out_data,  last.d);
      check("rnd_out_rd",    out_rd,    last.r);
      check("rnd_out_ctrl",  out_ctrl,  (q.size() > 0) ? last.c : 6'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter: DATA_W, default 32, width of the datapath payload (ALU result / store data).
REQ-002 Parameter: RD_W, default 5, width of the destination-register index.
REQ-003 Parameter: CTRL_W, default 6, width of the control bundle (WB select, register write enable, MEM request bits); bit 0 is register write enable.
REQ-004 Port: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-low.
REQ-006 Port: flush  input  1  synchronous kill of all held entries.
REQ-007 Port: in_valid  input  1  upstream entry present.
REQ-008 Port: in_ready  output  1  stage can accept an entry this cycle.
REQ-009 Port: in_data  input  DATA_W  payload.
REQ-010 Port: in_rd  input  RD_W  destination register index.
REQ-011 Port: in_ctrl  input  CTRL_W  control bundle.
REQ-012 Port: out_valid  output  1  output entry present.
REQ-013 Port: out_ready  input  1  downstream accepts this cycle.
REQ-014 Port: out_data  output  DATA_W  head payload.
REQ-015 Port: out_rd  output  RD_W  head destination index.
REQ-016 Port: out_ctrl  output  CTRL_W  head control bundle; all-zero when out_valid=0 (bubble).
REQ-017 Port: occupancy  output  2  number of held entries, 0..2.

Function
REQ-018 Storage SHALL be two entries: main (drives out_*) and skid; states EMPTY (0 entries), ONE (main), TWO (main+skid).
REQ-019 in_ready SHALL be 1 exactly when state is not TWO and rst is high, decoded from registers only (no combinational path from out_ready or in_valid).
REQ-020 out_valid SHALL be 1 exactly when state is not EMPTY, decoded from registers only.
REQ-021 An input transfer occurs on an edge with in_valid=1 and in_ready=1; an output transfer on an edge with out_valid=1 and out_ready=1.
REQ-022 EMPTY: input transfer -> main<=input, ONE; else stay.
REQ-023 ONE: input and output transfer -> main<=input, stay ONE; input only -> skid<=input, TWO; output only -> EMPTY; neither -> hold.
REQ-024 TWO: output transfer -> main<=skid, ONE; else hold; no input accepted.
REQ-025 Entries SHALL leave in arrival order; no entry duplicated or dropped except by flush/reset.
REQ-026 Latency: an entry accepted into EMPTY SHALL appear on out_* with out_valid=1 the next cycle.
REQ-027 Throughput: with out_ready held 1, one entry per cycle SHALL pass with no bubbles.
REQ-028 On entering EMPTY (drain or flush), out_ctrl SHALL become 0; out_data and out_rd hold their last values.
REQ-029 flush=1 SHALL take priority over all transfers: next state EMPTY, occupancy 0, out_ctrl 0; any input presented that cycle is discarded; the output transfer that cycle, if any, still counts as consumed downstream.
REQ-030 occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO, registered.
REQ-031 Payload widths SHALL pass unmodified; no arithmetic on data, rd or ctrl.

Reset
REQ-032 While rst=0, asynchronously: state EMPTY, out_valid 0, in_ready 0, out_data 0, out_rd 0, out_ctrl 0, occupancy 0, skid contents 0.
REQ-033 Reset mid-operation SHALL discard all held entries; after rst rises, the first rising edge with in_valid=1 SHALL be accepted.

Verification
REQ-034 Pass-through: out_ready=1, inputs data 0x11,0x22,0x33 on consecutive cycles, ctrl 6'h01 -> out_data 0x11,0x22,0x33 one cycle later each, out_valid continuous, occupancy 1.
REQ-035 Back-pressure: out_ready=0, in_valid=1 with 0xA,0xB,0xC -> 0xA in main, 0xB in skid, in_ready=0 after second accept, occupancy 2, 0xC held upstream; raise out_ready -> output 0xA,0xB,0xC in order.
REQ-036 Simultaneous in/out in ONE: main=0x5, in 0x6 with out_ready=1 -> out_data 0x6 next cycle, occupancy stays 1.
REQ-037 Flush in TWO with in_valid=1 data 0x9 -> next cycle out_valid 0, out_ctrl 0, occupancy 0, in_ready 1; 0x9 never appears.
REQ-038 Async reset asserted mid-cycle with occupancy 2 -> outputs zero immediately without a clock edge; after release, in_ready 1 and a new entry 0x77 appears next cycle.
